load_store_unit: RTL
====================

# load_store_unit

Sequential load/store unit between the execute stage and the word-wide data memory. Takes the 3-bit `AddrMode` access code from the control unit, plus the ALU-computed address and store data. Runs a handshake with the memory port, generating byte enables and lane-steered store data. Returns sign/zero-extended load data and stalls the core until the access completes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of data path and memory word (fixed at 32; byte-enable logic assumes 4 lanes)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  execute stage presents a load/store this cycle
- `AddrMode`  in  3  access code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- `addr`  in  ADDR_WIDTH  byte address from ALU
- `wdata`  in  DATA_WIDTH  store data (rs2)
- `stall`  out  1  core must hold its pipeline
- `done`  out  1  one-cycle pulse: access finished (or rejected)
- `rdata`  out  DATA_WIDTH  extended load result; valid when `done` is high and the access was a load
- `misaligned`  out  1  one-cycle pulse coincident with `done`: access rejected
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_be`  out  4  byte enables
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (`addr[1:0]` forced to 00)
- `mem_wdata`  out  DATA_WIDTH  lane-steered store data
- `mem_ready`  in  1  memory completes the access this cycle
- `mem_rdata`  in  DATA_WIDTH  read word; valid when `mem_ready` is high and `mem_we` is low

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On `req_valid`, latch `AddrMode`, `addr`, `wdata`.
  - If the access is aligned, go to BUSY. If not, go to RESP with the error flag set.
- Alignment rule:
  - Byte accesses are always aligned.
  - LH, LHU, SH need `addr[0]`=0.
  - LW, SW need `addr[1:0]`=00.
- BUSY:
  - `mem_req`=1; `mem_we`=1 for codes 101–111.
  - All memory outputs are driven from latched registers and stay stable until `mem_ready`.
  - On `mem_ready`, register the extracted load data and go to RESP.
- RESP:
  - `done`=1; `misaligned`=error flag.
  - Always return to IDLE. Requests are accepted only in IDLE.
- Byte enables:
  - SB: `0001 << a[1:0]`.
  - SH: `0011 << a[1:0]`.
  - SW: `1111`.
  - Loads: `1111`.
- Store data:
  - SB replicates `wdata[7:0]` to all 4 lanes.
  - SH replicates `wdata[15:0]` to both halves.
  - SW passes `wdata` through.
- Load extraction:
  - Byte lane `a[1:0]`, half lane `a[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `rdata` output:
  - Holds the last load result until the next load completes.
  - Stores and rejected accesses leave `rdata` unchanged.
- `stall` = (IDLE && `req_valid`) || BUSY. `stall` is low in RESP, so the core advances at the end of RESP.

## Timing
- Reset values: state IDLE; all outputs 0 (`stall`, `done`, `rdata`, `misaligned`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`).
- Latency:
  - Request in IDLE at cycle n; `mem_req` high from n+1.
  - First `mem_ready` at cycle m gives `done` at m+1.
  - Minimum (zero-wait memory): `done` at n+2.
- Misaligned: request at n gives `done`=`misaligned`=1 at n+1. `mem_req` is never asserted.
- `mem_ready` while not in BUSY is ignored.
- `req_valid` in BUSY or RESP is ignored; the core is stalled or advancing.
- Asynchronous reset mid-BUSY: `mem_req` drops immediately, the access is abandoned, and no `done` is issued.

## Structure
- Package `lsu_pkg`:
  - `addr_mode_t` enum with the 3-bit encoding above (shared with the control unit).
  - `lsu_state_t` enum.
  - Lane constants `BE_BYTE`=4'b0001, `BE_HALF`=4'b0011, `BE_WORD`=4'b1111.
- One combinational sub-module, `lsu_align`:
  - Inputs: mode, `addr[1:0]`, `wdata`, `mem_rdata`.
  - Outputs: `mem_be`, steered `mem_wdata`, extended load data, misaligned flag.
- The FSM and registers live in `load_store_unit`.

## Test plan
- LW, addr 0x100, zero-wait memory returning 0xDEADBEEF: `mem_addr`=0x100, `mem_be`=1111, `done` at n+2, `rdata`=0xDEADBEEF, `stall` high for 2 cycles.
- LB/LBU, addr 0x103, `mem_rdata`=0x80FF_1234: LB gives 0xFFFFFF80, LBU gives 0x00000080. LH/LHU at 0x102 give 0xFFFF80FF / 0x000080FF.
- SB, addr 0x101, `wdata`=0x000000AB: `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xABABABAB. SH at 0x102, `wdata` 0x1234: `mem_be`=1100, `mem_wdata`=0x12341234.
- SW at 0x102: `misaligned`=`done`=1 at n+1, `mem_req` never high, `rdata` unchanged.
- LW with 3 wait states (`mem_ready` low 3 cycles): `mem_req`, `mem_addr`, `mem_be` stable throughout, `stall` high, `done` one cycle after `mem_ready`.
- Assert `rst_n` low during BUSY: `mem_req` 0 immediately, all outputs 0, no `done`. A new LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// addr_mode_t carries the same 3-bit encoding the control unit drives on AddrMode.
package lsu_pkg;

  typedef enum logic [2:0] {
    ModeLb  = 3'b000,
    ModeLh  = 3'b001,
    ModeLw  = 3'b010,
    ModeLbu = 3'b011,
    ModeLhu = 3'b100,
    ModeSb  = 3'b101,
    ModeSh  = 3'b110,
    ModeSw  = 3'b111
  } addr_mode_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StResp = 2'b10
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_store(addr_mode_t mode);
    return (mode == ModeSb) || (mode == ModeSh) || (mode == ModeSw);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   mode       access code (addr_mode_t encoding)
//   addr_lo    byte offset within the word
//   wdata      store data as supplied by the core
//   mem_rdata  word returned by memory
//   mem_be     byte enables for the access
//   mem_wdata  store data replicated onto the addressed lanes
//   load_data  selected lane, sign/zero-extended to 32 bits
//   misaligned access does not meet its natural alignment
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  addr_mode_t  mode_e;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mode_e   = addr_mode_t'(mode);
  assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    mem_be     = BE_WORD;
    mem_wdata  = wdata;
    load_data  = mem_rdata;
    misaligned = 1'b0;
    unique case (mode_e)
      ModeLb:  load_data = {{24{byte_sel[7]}}, byte_sel};
      ModeLbu: load_data = {24'h0, byte_sel};
      ModeLh: begin
        misaligned = addr_lo[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      ModeLhu: begin
        misaligned = addr_lo[0];
        load_data  = {16'h0, half_sel};
      end
      ModeLw:  misaligned = |addr_lo;
      ModeSb: begin
        mem_be    = BE_BYTE << addr_lo;
        mem_wdata = {4{wdata[7:0]}};
      end
      ModeSh: begin
        misaligned = addr_lo[0];
        mem_be     = BE_HALF << addr_lo;
        mem_wdata  = {2{wdata[15:0]}};
      end
      ModeSw:  misaligned = |addr_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit between execute and a word-wide data memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid           execute stage presents an access
//   AddrMode            access code (see lsu_pkg::addr_mode_t)
//   addr, wdata         byte address and store data
//   stall               hold the pipeline
//   done, misaligned    completion pulse, rejection flag (same cycle)
//   rdata               last completed load result
//   mem_req, mem_we     memory request / write
//   mem_be, mem_addr    byte enables, word-aligned address
//   mem_wdata           lane-steered store data
//   mem_ready, mem_rdata memory completion and read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [2:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  addr_mode_t            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic       idle, busy, resp, accept;
  logic [2:0] align_mode;
  logic [1:0] align_addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] steered_wdata;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  align_err;

  assign idle   = (state_q == StIdle);
  assign busy   = (state_q == StBusy);
  assign resp   = (state_q == StResp);
  assign accept = idle && req_valid;

  // In IDLE the aligner checks the live request; afterwards it works on the latched one.
  assign align_mode = idle ? AddrMode   : mode_q;
  assign align_addr = idle ? addr[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .mode       (align_mode),
    .addr_lo    (align_addr),
    .wdata      (wdata_q),
    .mem_rdata  (mem_rdata),
    .mem_be     (be),
    .mem_wdata  (steered_wdata),
    .load_data  (load_data),
    .misaligned (align_err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = align_err ? StResp : StBusy;
      StBusy:  if (mem_ready) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeLb;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= addr_mode_t'(AddrMode);
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= align_err;
      end
      if (busy && mem_ready && !is_store(mode_q)) begin
        rdata_q <= load_data;
      end
    end
  end

  // Memory-side outputs are zero outside BUSY so nothing leaks from latched state.
  always_comb begin
    stall      = accept || busy;
    done       = resp;
    misaligned = resp && err_q;
    rdata      = rdata_q;
    mem_req    = busy;
    mem_we     = busy && is_store(mode_q);
    mem_be     = busy ? be : 4'b0000;
    mem_addr   = busy ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata  = busy ? steered_wdata : '0;
  end

endmodule
